// File: rtl/rr_packet_arbiter_if.sv
// Bundle of the source-side and sink-side ready/valid signals shared by the
// round-robin packet arbiter. "master" is the environment that owns the
// sources and the sink; "slave" is the arbiter itself.
interface rr_packet_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int LW = $clog2(N);

    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_bits;
    logic [N-1:0]   in_last;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_bits;
    logic           out_last;
    logic [LW-1:0]  out_chosen;
    logic           out_locked;
    logic           err_overrun;

    modport master (
        output in_valid, in_bits, in_last, out_ready,
        input  in_ready, out_valid, out_bits, out_last, out_chosen,
               out_locked, err_overrun
    );

    modport slave (
        input  in_valid, in_bits, in_last, out_ready,
        output in_ready, out_valid, out_bits, out_last, out_chosen,
               out_locked, err_overrun
    );
endinterface

// File: rtl/rr_packet_arbiter.sv
// Round-robin arbiter sharing one ready/valid sink between N packet sources.
// The grant locks to a source after its first beat and stays until its last
// beat, or until a beat counter forces release after MAX_BEATS beats.
// The datapath is purely combinational; only the arbitration state is stored.
module rr_packet_arbiter #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic               clk,
    input  logic               reset,
    rr_packet_arbiter_if.slave bus
);
    localparam int LW = $clog2(N);
    localparam int CW = $clog2(MAX_BEATS);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [LW-1:0]   r_lastGrant;
    logic [LW-1:0]   w_lastGrantNext;
    logic [LW-1:0]   r_lockId;
    logic [LW-1:0]   w_lockIdNext;
    logic [CW-1:0]   r_beatCnt;
    logic [CW-1:0]   w_beatCntNext;
    logic            r_errOverrun;
    logic            w_errNext;
    logic [LW-1:0]   w_rrPick;
    logic [LW-1:0]   w_choose;
    logic            w_fire;

    // Round-robin pick: first valid source above last_grant, else wrap to the
    // lowest valid source; with nobody valid the pick parks on N-1.
    always_comb begin
        logic found;
        found    = 1'b0;
        w_rrPick = LW'(N - 1);
        for (int i = 0; i < N; i++) begin
            if (!found && bus.in_valid[i] && (LW'(i) > r_lastGrant)) begin
                w_rrPick = LW'(i);
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && bus.in_valid[i]) begin
                w_rrPick = LW'(i);
                found    = 1'b1;
            end
        end
    end

    assign w_choose = (r_state == S_LOCKED) ? r_lockId : w_rrPick;

    // Zero-latency mux from the chosen source to the sink, and ready fan-out
    // back to the chosen source only.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_bits  = '0;
        bus.in_ready  = '0;
        for (int i = 0; i < N; i++) begin
            if (LW'(i) == w_choose) begin
                bus.out_valid   = bus.in_valid[i];
                bus.out_last    = bus.in_last[i];
                bus.out_bits    = bus.in_bits[i*W +: W];
                bus.in_ready[i] = bus.out_ready;
            end
        end
    end

    assign w_fire          = bus.out_valid & bus.out_ready;
    assign bus.out_chosen  = w_choose;
    assign bus.out_locked  = (r_state == S_LOCKED);
    assign bus.err_overrun = r_errOverrun;

    // Lock/release decisions; last_grant only moves when a packet ends.
    always_comb begin
        w_stateNext     = r_state;
        w_lastGrantNext = r_lastGrant;
        w_lockIdNext    = r_lockId;
        w_beatCntNext   = r_beatCnt;
        w_errNext       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fire) begin
                    if (bus.out_last) begin
                        w_lastGrantNext = w_choose;
                    end else begin
                        w_stateNext   = S_LOCKED;
                        w_lockIdNext  = w_choose;
                        w_beatCntNext = CW'(1);
                    end
                end
            end
            S_LOCKED: begin
                if (w_fire) begin
                    if (bus.out_last) begin
                        w_stateNext     = S_IDLE;
                        w_lastGrantNext = r_lockId;
                        w_beatCntNext   = '0;
                    end else if (r_beatCnt == CW'(MAX_BEATS - 1)) begin
                        w_stateNext     = S_IDLE;
                        w_lastGrantNext = r_lockId;
                        w_beatCntNext   = '0;
                        w_errNext       = 1'b1;
                    end else begin
                        w_beatCntNext = r_beatCnt + CW'(1);
                    end
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Arbitration state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_lastGrant  <= '0;
            r_lockId     <= '0;
            r_beatCnt    <= '0;
            r_errOverrun <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_lastGrant  <= w_lastGrantNext;
            r_lockId     <= w_lockIdNext;
            r_beatCnt    <= w_beatCntNext;
            r_errOverrun <= w_errNext;
        end
    end
endmodule
